// File: rtl/io_stream_write_array.sv
`default_nettype none
// ============================================================================
// Module   : io_stream_write_array
// Purpose  : Streams a contiguous array region out, one word per cycle,
//            through a 2-entry FIFO that absorbs read latency and backpressure.
// Revision : 1.0  initial release
// ============================================================================
module io_stream_write_array #(
    parameter int intN  = 8,
    parameter int addrN = 8
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic [addrN-1:0] base,
    input  logic [addrN:0]   len,
    output logic [addrN-1:0] arr_addr,
    output logic             arr_we,
    output logic [intN-1:0]  arr_di,
    output logic             arr_valid,
    input  logic             arr_ready,
    input  logic [intN-1:0]  arr_do,
    output logic [intN-1:0]  sOut,
    output logic             sOut_valid,
    input  logic             sOut_ready
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [addrN-1:0]  r_addr;
    logic [addrN:0]    r_remaining;
    logic [addrN:0]    r_len;
    logic [addrN:0]    r_sent;
    logic              r_inflight;

    logic [intN-1:0]   r_mem [0:1];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_count;

    logic              w_push;
    logic              w_pop;
    logic              w_start;
    logic              w_issue;
    logic              w_accept;
    logic [2:0]        w_used;
    logic [2:0]        w_cap;
    logic [addrN:0]    w_sent_inc;

    assign w_start    = (r_state == S_IDLE) && in_valid;
    assign w_push     = r_inflight;
    assign sOut_valid = (r_count != 2'd0);
    assign sOut       = r_mem[r_rd_ptr];
    assign w_pop      = sOut_valid && sOut_ready;
    assign w_sent_inc = r_sent + {{addrN{1'b0}}, 1'b1};

    // A beat leaving the FIFO this cycle frees its slot for a read issued now,
    // which is what sustains one element per cycle.
    assign w_used   = {1'b0, r_count} + {2'b00, r_inflight};
    assign w_cap    = 3'd2 + {2'b00, w_pop};
    assign w_issue  = (r_state == S_RUN) && (r_remaining != '0) && (w_used < w_cap);
    assign w_accept = w_issue && arr_ready;

    assign arr_valid = w_issue;
    assign arr_addr  = r_addr;
    assign arr_we    = 1'b0;
    assign arr_di    = '0;
    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (in_valid) w_state_next = (len == '0) ? S_DONE : S_RUN;
            S_RUN:  if (w_pop && (w_sent_inc == r_len)) w_state_next = S_DONE;
            S_DONE: if (out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_len       <= '0;
            r_sent      <= '0;
            r_inflight  <= 1'b0;
        end else begin
            r_inflight <= w_accept;
            if (w_start) begin
                r_addr      <= base;
                r_remaining <= len;
                r_len       <= len;
                r_sent      <= '0;
            end else begin
                if (w_accept) begin
                    r_addr      <= r_addr + {{(addrN-1){1'b0}}, 1'b1};
                    r_remaining <= r_remaining - {{addrN{1'b0}}, 1'b1};
                end
                if (w_pop) begin
                    r_sent <= w_sent_inc;
                end
            end
        end
    end

    // Read data returns exactly one cycle after acceptance, straight into the tail.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= arr_do;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!nrst)
        !(w_push && !w_pop && (r_count == 2'd2)));

endmodule
`default_nettype wire

// File: tb/tb_io_stream_write_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_stream_write_array
// Purpose  : Directed self-checking bench for io_stream_write_array.
// Revision : 1.0  initial release
// ============================================================================
module tb_io_stream_write_array;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] base = 8'd0;
    logic [8:0] len = 9'd0;
    logic [7:0] arr_addr;
    logic       arr_we;
    logic [7:0] arr_di;
    logic       arr_valid;
    logic       arr_ready = 1'b1;
    logic [7:0] arr_do = 8'd0;
    logic [7:0] sOut;
    logic       sOut_valid;
    logic       sOut_ready = 1'b1;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem [0:255];

    io_stream_write_array #(.intN(8), .addrN(8)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .base       (base),
        .len        (len),
        .arr_addr   (arr_addr),
        .arr_we     (arr_we),
        .arr_di     (arr_di),
        .arr_valid  (arr_valid),
        .arr_ready  (arr_ready),
        .arr_do     (arr_do),
        .sOut       (sOut),
        .sOut_valid (sOut_valid),
        .sOut_ready (sOut_ready)
    );

    always #5 clk = ~clk;

    // Array model: one-cycle read latency.
    always @(posedge clk) begin
        if (arr_valid && arr_ready) arr_do <= mem[arr_addr];
    end

    function automatic logic [7:0] expv(input int a);
        logic [7:0] r;
        r = 8'((a % 256) + 100);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drives one start request; returns at cycle T+1 with inputs settled.
    task automatic start_job(input logic [7:0] b, input logic [8:0] l);
        base = b; len = l; in_valid = 1'b1;
        #1;
        check("start_in_ready", {31'd0, in_ready}, 32'd1);
        cyc();
        in_valid = 1'b0;
        base = 8'hEE; len = 9'd77;
        #1;
    endtask

    // Streams until completion; optionally randomises both ready inputs.
    task automatic run_stream(input int b, input int l, input bit rnd, input int budget);
        int  beats = 0;
        int  issued = 0;
        int  over = 0;
        bit  held = 0;
        logic [7:0] held_v = 8'd0;
        bit  done = 0;
        for (int c = 0; c < budget && !done; c++) begin
            if (rnd) begin
                sOut_ready = ($urandom_range(0, 1) == 1);
                arr_ready  = ($urandom_range(0, 3) != 0);
            end
            #1;
            if (out_valid) begin
                done = 1;
            end else begin
                if (held) begin
                    check("stall_valid", {31'd0, sOut_valid}, 32'd1);
                    check("stall_hold", {24'd0, sOut}, {24'd0, held_v});
                end
                if (arr_valid && arr_ready) issued++;
                if (sOut_valid && sOut_ready) begin
                    check($sformatf("beat%0d", beats), {24'd0, sOut}, {24'd0, expv(b + beats)});
                    beats++;
                end
                if (issued > beats + 2) over++;
                held   = sOut_valid && !sOut_ready;
                held_v = sOut;
                @(posedge clk);
                #1;
            end
        end
        if (!done) check("stream_timeout", 32'd0, 32'd1);
        check("beat_count", beats, l);
        check("read_ahead", over, 0);
        sOut_ready = 1'b1;
        arr_ready  = 1'b1;
    endtask

    task automatic finish_job();
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        #1;
        check("in_ready_back", {31'd0, in_ready}, 32'd1);
        check("out_valid_clr", {31'd0, out_valid}, 32'd0);
    endtask

    int rd;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i + 100);

        // Reset values
        #2;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_arr_valid", {31'd0, arr_valid}, 32'd0);
        check("rst_arr_addr", {24'd0, arr_addr}, 32'd0);
        check("rst_sout_valid", {31'd0, sOut_valid}, 32'd0);
        check("rst_sout", {24'd0, sOut}, 32'd0);
        check("arr_we", {31'd0, arr_we}, 32'd0);
        check("arr_di", {24'd0, arr_di}, 32'd0);
        cyc(); cyc();
        nrst = 1'b1;
        cyc();

        // base=4, len=5, all ready
        start_job(8'd4, 9'd5);
        check("t1_arr_valid", {31'd0, arr_valid}, 32'd1);
        check("t1_arr_addr", {24'd0, arr_addr}, 32'd4);
        check("t1_sv", {31'd0, sOut_valid}, 32'd0);
        check("t1_in_ready", {31'd0, in_ready}, 32'd0);
        cyc();
        check("t2_arr_addr", {24'd0, arr_addr}, 32'd5);
        check("t2_sv", {31'd0, sOut_valid}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            cyc();
            check("t1_beat_valid", {31'd0, sOut_valid}, 32'd1);
            check("t1_beat_data", {24'd0, sOut}, 104 + k);
        end
        cyc();
        check("t1_out_valid", {31'd0, out_valid}, 32'd1);
        check("t1_sv_done", {31'd0, sOut_valid}, 32'd0);
        check("t1_arr_valid_done", {31'd0, arr_valid}, 32'd0);
        cyc();
        check("t1_out_held", {31'd0, out_valid}, 32'd1);
        finish_job();

        // Address wrap; in_valid during RUN is ignored
        start_job(8'd254, 9'd4);
        for (int k = 0; k < 4; k++) begin
            if (k == 1) begin in_valid = 1'b1; base = 8'd0; len = 9'd1; #1; end
            check("wrap_addr", {24'd0, arr_addr}, (254 + k) % 256);
            check("wrap_arr_valid", {31'd0, arr_valid}, 32'd1);
            if (k >= 2) check("wrap_data", {24'd0, sOut}, {24'd0, expv(254 + k - 2)});
            cyc();
        end
        in_valid = 1'b0;
        #1;
        check("wrap_data", {24'd0, sOut}, {24'd0, expv(256)});
        cyc();
        check("wrap_data", {24'd0, sOut}, {24'd0, expv(257)});
        cyc();
        check("wrap_out_valid", {31'd0, out_valid}, 32'd1);
        finish_job();

        // len = 0
        start_job(8'd9, 9'd0);
        check("len0_out_valid", {31'd0, out_valid}, 32'd1);
        check("len0_arr_valid", {31'd0, arr_valid}, 32'd0);
        check("len0_sv", {31'd0, sOut_valid}, 32'd0);
        finish_job();

        // Backpressure: sOut_ready low for 10 cycles
        sOut_ready = 1'b0;
        start_job(8'd10, 9'd6);
        rd = 0;
        for (int k = 0; k < 10; k++) begin
            if (arr_valid && arr_ready) rd++;
            cyc();
        end
        check("bp_reads", rd, 2);
        check("bp_arr_valid", {31'd0, arr_valid}, 32'd0);
        check("bp_sv", {31'd0, sOut_valid}, 32'd1);
        check("bp_head", {24'd0, sOut}, 32'd110);
        sOut_ready = 1'b1;
        #1;
        check("bp_resume_arr_valid", {31'd0, arr_valid}, 32'd1);
        run_stream(10, 6, 1'b0, 40);
        finish_job();

        // Random stalls on both sides, len=20
        start_job(8'd30, 9'd20);
        run_stream(30, 20, 1'b1, 600);
        finish_job();

        // Reset mid-stream after 3 beats
        start_job(8'd50, 9'd10);
        cyc(); cyc(); cyc(); cyc();
        check("pre_rst_data", {24'd0, sOut}, 32'd152);
        cyc();
        nrst = 1'b0;
        #1;
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_arr_valid", {31'd0, arr_valid}, 32'd0);
        check("mid_rst_arr_addr", {24'd0, arr_addr}, 32'd0);
        check("mid_rst_sv", {31'd0, sOut_valid}, 32'd0);
        check("mid_rst_sout", {24'd0, sOut}, 32'd0);
        cyc();
        nrst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
            check("post_rst_sv", {31'd0, sOut_valid}, 32'd0);
        end
        start_job(8'd0, 9'd2);
        cyc(); cyc();
        check("new_beat0", {24'd0, sOut}, 32'd100);
        check("new_beat0_v", {31'd0, sOut_valid}, 32'd1);
        cyc();
        check("new_beat1", {24'd0, sOut}, 32'd101);
        cyc();
        check("new_out_valid", {31'd0, out_valid}, 32'd1);
        finish_job();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
